// File: rtl/dds_sweep_pkg.sv
// Shared types and defaults for the DDS frequency-sweep sequencer.
package dds_sweep_pkg;

  localparam int unsigned PHASE_W_DEF = 32;
  localparam int unsigned DWELL_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable dwell down-counter; expire flags the cycle whose edge brings the count to zero.
module dds_dwell_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the DDS phase increment: stepped start->stop sweep
// with per-value dwell, single or repeating, up or down, abortable.
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               repeat_en,
  input  logic [PHASE_W-1:0] f_start,
  input  logic [PHASE_W-1:0] f_stop,
  input  logic [PHASE_W-1:0] f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               busy,
  output logic               step_stb,
  output logic               done
);

  state_t             state, state_nx;
  dir_t               dir_sh;
  logic [PHASE_W-1:0] start_sh, stop_sh, step_sh;
  logic [DWELL_W-1:0] dwell_sh;
  logic               rep_sh;

  logic [PHASE_W-1:0] phase_inc_nx;
  logic               busy_nx, step_stb_nx, done_nx;
  logic               tmr_load, tmr_expire;
  logic [DWELL_W-1:0] tmr_value;

  logic [PHASE_W:0]   next_sum;
  logic               sweep_end;
  logic               capture;

  assign capture = (state == IDLE) && start && !abort;

  dds_dwell_timer #(.W(DWELL_W)) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_sh <= '0;
      stop_sh  <= '0;
      step_sh  <= '0;
      dwell_sh <= '0;
      rep_sh   <= 1'b0;
      dir_sh   <= DOWN;
    end else if (capture) begin
      start_sh <= f_start;
      stop_sh  <= f_stop;
      step_sh  <= f_step;
      dwell_sh <= dwell;
      rep_sh   <= repeat_en;
      dir_sh   <= (f_stop >= f_start) ? UP : DOWN;
    end
  end

  // Bit PHASE_W carries the add carry or the subtract borrow.
  always_comb begin
    if (dir_sh == UP) begin
      next_sum = {1'b0, phase_inc} + {1'b0, step_sh};
    end else begin
      next_sum = {1'b0, phase_inc} - {1'b0, step_sh};
    end
  end

  always_comb begin
    sweep_end = 1'b0;
    if (step_sh == '0 || next_sum[PHASE_W]) begin
      sweep_end = 1'b1;
    end else if (dir_sh == UP) begin
      sweep_end = (next_sum[PHASE_W-1:0] > stop_sh);
    end else begin
      sweep_end = (next_sum[PHASE_W-1:0] < stop_sh);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A zero dwell skips RUN entirely: every cycle is an evaluation cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (capture) state_nx = (dwell == '0) ? STEP : RUN;
      RUN: begin
        if (abort)           state_nx = IDLE;
        else if (tmr_expire) state_nx = STEP;
      end
      STEP: begin
        if (abort)                     state_nx = IDLE;
        else if (sweep_end && !rep_sh) state_nx = IDLE;
        else                           state_nx = (dwell_sh == '0) ? STEP : RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    phase_inc_nx = phase_inc;
    busy_nx      = busy;
    step_stb_nx  = 1'b0;
    done_nx      = 1'b0;
    tmr_load     = 1'b0;
    tmr_value    = dwell_sh;
    if (abort && state != IDLE) begin
      phase_inc_nx = '0;
      busy_nx      = 1'b0;
      tmr_load     = 1'b1;
      tmr_value    = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (capture) begin
            phase_inc_nx = f_start;
            busy_nx      = 1'b1;
            step_stb_nx  = 1'b1;
            tmr_load     = 1'b1;
            tmr_value    = dwell;
          end
        end
        STEP: begin
          if (sweep_end) begin
            done_nx = 1'b1;
            if (rep_sh) begin
              phase_inc_nx = start_sh;
              step_stb_nx  = 1'b1;
              tmr_load     = 1'b1;
            end else begin
              busy_nx = 1'b0;
            end
          end else begin
            phase_inc_nx = next_sum[PHASE_W-1:0];
            step_stb_nx  = 1'b1;
            tmr_load     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_inc <= '0;
      busy      <= 1'b0;
      step_stb  <= 1'b0;
      done      <= 1'b0;
    end else begin
      phase_inc <= phase_inc_nx;
      busy      <= busy_nx;
      step_stb  <= step_stb_nx;
      done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: expected per-cycle {phase_inc,busy,step_stb,done} tables.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, repeat_en;
  logic [31:0] f_start, f_stop, f_step;
  logic [15:0] dwell;
  logic [31:0] phase_inc;
  logic        busy, step_stb, done;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [34:0] exp_q[$];

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.PHASE_W(32), .DWELL_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .repeat_en (repeat_en),
    .f_start   (f_start),
    .f_stop    (f_stop),
    .f_step    (f_step),
    .dwell     (dwell),
    .phase_inc (phase_inc),
    .busy      (busy),
    .step_stb  (step_stb),
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A value is strobed on its first cycle and held dw further cycles.
  function automatic void add_value(logic [31:0] v, int unsigned dw);
    exp_q.push_back({v, 1'b1, 1'b1, 1'b0});
    for (int unsigned k = 0; k < dw; k++) exp_q.push_back({v, 1'b1, 1'b0, 1'b0});
  endfunction

  function automatic void add_end(logic [31:0] v);
    exp_q.push_back({v, 1'b0, 1'b0, 1'b1});
    exp_q.push_back({v, 1'b0, 1'b0, 1'b0});
  endfunction

  // Configuration is scrambled right after the start edge; the sweep must ignore it.
  task automatic kick(logic [31:0] s, logic [31:0] e, logic [31:0] st, logic [15:0] d, logic rep);
    f_start = s; f_stop = e; f_step = st; dwell = d; repeat_en = rep;
    start = 1'b1;
    tick();
    start = 1'b0;
    f_start = 32'h0000_DEAD; f_stop = 32'h0; f_step = 32'h1; dwell = 16'd7; repeat_en = ~rep;
  endtask

  task automatic test_reset();
    tests++;
    if ({phase_inc, busy, step_stb, done} !== 35'h0) begin
      fails++;
      $display("FAIL reset: got phase_inc=%0d busy=%b stb=%b done=%b, want all 0", phase_inc, busy, step_stb, done);
    end
  endtask

  task automatic test_abort_idle();
    f_start = 32'd50; f_stop = 32'd60; f_step = 32'd5; dwell = 16'd0; repeat_en = 1'b0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({busy, step_stb, done} !== 3'b000) begin
        fails++;
        $display("FAIL abort_idle[%0d]: got busy=%b stb=%b done=%b, want 0 0 0", i, busy, step_stb, done);
      end
      tick();
    end
  endtask

  task automatic test_up_sweep(input string tag);
    exp_q.delete();
    add_value(32'd100, 2); add_value(32'd110, 2); add_value(32'd120, 2); add_value(32'd130, 2);
    add_end(32'd130);
    kick(32'd100, 32'd130, 32'd10, 16'd2, 1'b0);
    foreach (exp_q[i]) begin
      tests++;
      if ({phase_inc, busy, step_stb, done} !== exp_q[i]) begin
        fails++;
        $display("FAIL %s[%0d]: got phase_inc=%0d busy=%b stb=%b done=%b, want phase_inc=%0d busy=%b stb=%b done=%b",
                 tag, i, phase_inc, busy, step_stb, done, exp_q[i][34:3], exp_q[i][2], exp_q[i][1], exp_q[i][0]);
      end
      tick();
    end
  endtask

  task automatic test_nonexact_stop();
    exp_q.delete();
    add_value(32'd100, 0); add_value(32'd110, 0); add_value(32'd120, 0);
    add_end(32'd120);
    kick(32'd100, 32'd125, 32'd10, 16'd0, 1'b0);
    foreach (exp_q[i]) begin
      tests++;
      if ({phase_inc, busy, step_stb, done} !== exp_q[i]) begin
        fails++;
        $display("FAIL nonexact[%0d]: got phase_inc=%0d busy=%b stb=%b done=%b, want phase_inc=%0d busy=%b stb=%b done=%b",
                 i, phase_inc, busy, step_stb, done, exp_q[i][34:3], exp_q[i][2], exp_q[i][1], exp_q[i][0]);
      end
      tick();
    end
  endtask

  task automatic test_down_sweep();
    exp_q.delete();
    add_value(32'd130, 1); add_value(32'd115, 1); add_value(32'd100, 1);
    add_end(32'd100);
    kick(32'd130, 32'd100, 32'd15, 16'd1, 1'b0);
    foreach (exp_q[i]) begin
      tests++;
      if ({phase_inc, busy, step_stb, done} !== exp_q[i]) begin
        fails++;
        $display("FAIL down[%0d]: got phase_inc=%0d busy=%b stb=%b done=%b, want phase_inc=%0d busy=%b stb=%b done=%b",
                 i, phase_inc, busy, step_stb, done, exp_q[i][34:3], exp_q[i][2], exp_q[i][1], exp_q[i][0]);
      end
      tick();
    end
    exp_q.delete();
    add_value(32'd130, 1);
    add_end(32'd130);
    kick(32'd130, 32'd100, 32'd40, 16'd1, 1'b0);
    foreach (exp_q[i]) begin
      tests++;
      if ({phase_inc, busy, step_stb, done} !== exp_q[i]) begin
        fails++;
        $display("FAIL down_big[%0d]: got phase_inc=%0d busy=%b stb=%b done=%b, want phase_inc=%0d busy=%b stb=%b done=%b",
                 i, phase_inc, busy, step_stb, done, exp_q[i][34:3], exp_q[i][2], exp_q[i][1], exp_q[i][0]);
      end
      tick();
    end
  endtask

  task automatic test_overflow();
    exp_q.delete();
    add_value(32'hFFFF_FFF0, 0);
    add_end(32'hFFFF_FFF0);
    kick(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 1'b0);
    foreach (exp_q[i]) begin
      tests++;
      if ({phase_inc, busy, step_stb, done} !== exp_q[i]) begin
        fails++;
        $display("FAIL overflow[%0d]: got phase_inc=%h busy=%b stb=%b done=%b, want phase_inc=%h busy=%b stb=%b done=%b",
                 i, phase_inc, busy, step_stb, done, exp_q[i][34:3], exp_q[i][2], exp_q[i][1], exp_q[i][0]);
      end
      tick();
    end
    exp_q.delete();
    add_value(32'd100, 1);
    add_end(32'd100);
    kick(32'd100, 32'd130, 32'd0, 16'd1, 1'b0);
    foreach (exp_q[i]) begin
      tests++;
      if ({phase_inc, busy, step_stb, done} !== exp_q[i]) begin
        fails++;
        $display("FAIL zero_step[%0d]: got phase_inc=%0d busy=%b stb=%b done=%b, want phase_inc=%0d busy=%b stb=%b done=%b",
                 i, phase_inc, busy, step_stb, done, exp_q[i][34:3], exp_q[i][2], exp_q[i][1], exp_q[i][0]);
      end
      tick();
    end
  endtask

  task automatic test_repeat_abort();
    exp_q.delete();
    add_value(32'd0, 0); add_value(32'd10, 0); add_value(32'd20, 0);
    exp_q.push_back({32'd0, 1'b1, 1'b1, 1'b1});
    exp_q.push_back({32'd10, 1'b1, 1'b1, 1'b0});
    exp_q.push_back({32'd0, 1'b0, 1'b0, 1'b0});
    exp_q.push_back({32'd0, 1'b0, 1'b0, 1'b0});
    kick(32'd0, 32'd20, 32'd10, 16'd0, 1'b1);
    foreach (exp_q[i]) begin
      tests++;
      if ({phase_inc, busy, step_stb, done} !== exp_q[i]) begin
        fails++;
        $display("FAIL repeat[%0d]: got phase_inc=%0d busy=%b stb=%b done=%b, want phase_inc=%0d busy=%b stb=%b done=%b",
                 i, phase_inc, busy, step_stb, done, exp_q[i][34:3], exp_q[i][2], exp_q[i][1], exp_q[i][0]);
      end
      start = (i == 1);
      abort = (i == 4);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    kick(32'd100, 32'd130, 32'd10, 16'd2, 1'b0);
    repeat (4) tick();
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({phase_inc, busy, step_stb, done} !== 35'h0) begin
      fails++;
      $display("FAIL reset_mid: got phase_inc=%0d busy=%b stb=%b done=%b, want all 0", phase_inc, busy, step_stb, done);
    end
    #3 reset = 1'b1;
    tick();
    tests++;
    if ({phase_inc, busy, step_stb, done} !== 35'h0) begin
      fails++;
      $display("FAIL reset_release: got phase_inc=%0d busy=%b stb=%b done=%b, want all 0", phase_inc, busy, step_stb, done);
    end
    test_up_sweep("up_after_reset");
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0; abort = 1'b0; repeat_en = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    #2;
    test_reset();
    #20 reset = 1'b1;
    tick();
    test_reset();
    test_abort_idle();
    test_up_sweep("up");
    test_nonexact_stop();
    test_down_sweep();
    test_overflow();
    test_repeat_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
